// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: picks camera-write or display-read SDRAM bursts,
// generates burst addresses and swaps ping-pong frame banks on frame starts.
module sdram_frame_arbiter #(
    parameter int unsigned BURST_LEN     = 256,
    parameter int unsigned FRAME_WORDS   = 384000,
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned LVL_W         = 10,
    parameter int unsigned RD_FIFO_DEPTH = 1024,
    parameter int unsigned RD_LOW        = 256
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              sdram_ack,
    input  logic              sdram_done,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic [7:0]        frame_drop_cnt
);

    localparam int unsigned       OFF_W     = ADDR_W - 1;
    localparam logic [OFF_W-1:0]  FRAME_OFF = OFF_W'(FRAME_WORDS);
    localparam logic [OFF_W-1:0]  BURST_OFF = OFF_W'(BURST_LEN);
    localparam logic [31:0]       WR_MIN    = 32'(BURST_LEN);
    localparam logic [31:0]       RD_MAX    = 32'(RD_FIFO_DEPTH - BURST_LEN);
    localparam logic [31:0]       RD_URG    = 32'(RD_LOW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [OFF_W-1:0]  wr_off, wr_off_n;
    logic [OFF_W-1:0]  rd_off, rd_off_n;
    logic              wr_bank_n, rd_bank_n;
    logic              ready_bank, ready_bank_n;
    logic              have_frame, have_frame_n;
    logic              wfs, wfs_n;
    logic              rfs, rfs_n;
    logic              last_grant, last_grant_n;   // 1 = last grant was a write
    logic              sdram_we_n;
    logic [ADDR_W-1:0] sdram_addr_n;
    logic [7:0]        drop_n;
    logic              wr_burst_done, rd_burst_done;
    logic              wr_elig, rd_elig, grant_w;

    assign sdram_req = (state == REQ);

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            wr_off         <= '0;
            rd_off         <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b1;
            ready_bank     <= 1'b1;
            have_frame     <= 1'b0;
            wfs            <= 1'b0;
            rfs            <= 1'b0;
            last_grant     <= 1'b1;
            sdram_we       <= 1'b0;
            sdram_addr     <= '0;
            frame_drop_cnt <= '0;
        end else begin
            state          <= state_n;
            wr_off         <= wr_off_n;
            rd_off         <= rd_off_n;
            wr_bank        <= wr_bank_n;
            rd_bank        <= rd_bank_n;
            ready_bank     <= ready_bank_n;
            have_frame     <= have_frame_n;
            wfs            <= wfs_n;
            rfs            <= rfs_n;
            last_grant     <= last_grant_n;
            sdram_we       <= sdram_we_n;
            sdram_addr     <= sdram_addr_n;
            frame_drop_cnt <= drop_n;
        end
    end

    // Next-state: offset advance, frame-start handling, then arbitration
    always_comb begin
        state_n       = state;
        wr_off_n      = wr_off;
        rd_off_n      = rd_off;
        wr_bank_n     = wr_bank;
        rd_bank_n     = rd_bank;
        ready_bank_n  = ready_bank;
        have_frame_n  = have_frame;
        wfs_n         = wfs | wr_frame_start;
        rfs_n         = rfs | rd_frame_start;
        last_grant_n  = last_grant;
        sdram_we_n    = sdram_we;
        sdram_addr_n  = sdram_addr;
        drop_n        = frame_drop_cnt;
        wr_elig       = 1'b0;
        rd_elig       = 1'b0;
        grant_w       = 1'b0;

        wr_burst_done = (state == BUSY) && sdram_done && sdram_we;
        rd_burst_done = (state == BUSY) && sdram_done && !sdram_we;

        if (wr_burst_done) wr_off_n = wr_off + BURST_OFF;
        if (rd_burst_done) rd_off_n = rd_off + BURST_OFF;

        // Frame starts act on the post-burst offsets so the eligibility
        // check below sees the already-reset stream in the same cycle.
        if (wfs_n && ((state == IDLE) || wr_burst_done)) begin
            if (wr_off_n == FRAME_OFF) begin
                ready_bank_n = wr_bank;
                wr_bank_n    = ~wr_bank;
                have_frame_n = 1'b1;
            end else if (frame_drop_cnt != 8'hFF) begin
                drop_n = frame_drop_cnt + 8'd1;
            end
            wr_off_n = '0;
            wfs_n    = 1'b0;
        end

        if (rfs_n && ((state == IDLE) || rd_burst_done)) begin
            rd_off_n = '0;
            if (have_frame_n) rd_bank_n = ready_bank_n;
            rfs_n = 1'b0;
        end

        case (state)
            IDLE: begin
                wr_elig = (32'(wr_fifo_level) >= WR_MIN) && (wr_off_n < FRAME_OFF);
                rd_elig = (32'(rd_fifo_level) <= RD_MAX) && (rd_off_n < FRAME_OFF);
                if (rd_elig && (32'(rd_fifo_level) < RD_URG))
                    grant_w = 1'b0;
                else if (wr_elig && rd_elig)
                    grant_w = ~last_grant;
                else
                    grant_w = wr_elig;
                if (wr_elig || rd_elig) begin
                    state_n      = REQ;
                    sdram_we_n   = grant_w;
                    sdram_addr_n = grant_w ? {wr_bank_n, wr_off_n} : {rd_bank_n, rd_off_n};
                    last_grant_n = grant_w;
                end
            end
            REQ:     if (sdram_ack)  state_n = BUSY;
            BUSY:    if (sdram_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed testbench for sdram_frame_arbiter.
module tb_sdram_frame_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [9:0]  wr_fifo_level = '0;
    logic [9:0]  rd_fifo_level = 10'd1000;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        sdram_req;
    logic        sdram_we;
    logic [23:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        sdram_done = 1'b0;
    logic        wr_bank;
    logic        rd_bank;
    logic [7:0]  frame_drop_cnt;

    int errors = 0;
    int checks = 0;

    sdram_frame_arbiter #(
        .BURST_LEN(256), .FRAME_WORDS(384000), .ADDR_W(24),
        .LVL_W(10), .RD_FIFO_DEPTH(1024), .RD_LOW(256)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_done(sdram_done),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_drop_cnt(frame_drop_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset();
        Rst = 1'b1;
        sdram_ack = 1'b0;
        sdram_done = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    // Serve one burst as the SDRAM controller; stop=1 idles both FIFOs once the request is seen
    task automatic burst(input bit stop, output logic we, output logic [23:0] addr, output bit ok);
        ok = 1'b0;
        we = 1'bx;
        addr = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (sdram_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            we = sdram_we;
            addr = sdram_addr;
            if (stop) begin
                wr_fifo_level = '0;
                rd_fifo_level = 10'd1000;
            end
            sdram_ack = 1'b1;
            @(posedge Clk);
            #1 sdram_ack = 1'b0;
            @(posedge Clk);
            #1 sdram_done = 1'b1;
            @(posedge Clk);
            #1 sdram_done = 1'b0;
        end
    endtask

    task automatic pulse_wfs();
        @(posedge Clk);
        #1 wr_frame_start = 1'b1;
        @(posedge Clk);
        #1 wr_frame_start = 1'b0;
        repeat (2) @(posedge Clk);
    endtask

    task automatic test_reset();
        wr_fifo_level = '0;
        rd_fifo_level = 10'd1000;
        do_reset();
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", sdram_req); end
        checks++; if (sdram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", sdram_we); end
        checks++; if (sdram_addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h expected 000000", sdram_addr); end
        checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank: got %b expected 0", wr_bank); end
        checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL reset_rd_bank: got %b expected 1", rd_bank); end
        checks++; if (frame_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", frame_drop_cnt); end
    endtask

    task automatic test_single_write();
        logic we; logic [23:0] addr; bit ok;
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd1000;
        do_reset();
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL sw_req_before_grant: got %b expected 0", sdram_req); end
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL sw_req_after_grant: got %b expected 1", sdram_req); end
        checks++; if (sdram_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", sdram_we); end
        checks++; if (sdram_addr !== 24'h000000) begin errors++; $display("FAIL sw_addr: got %h expected 000000", sdram_addr); end
        sdram_ack = 1'b1;
        @(posedge Clk);
        #1 sdram_ack = 1'b0;
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL sw_req_after_ack: got %b expected 0", sdram_req); end
        @(posedge Clk);
        #1 sdram_done = 1'b1;
        @(posedge Clk);
        #1 sdram_done = 1'b0;
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL sw_req_d1: got %b expected 0", sdram_req); end
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL sw_req_d2: got %b expected 1", sdram_req); end
        checks++; if (sdram_addr !== 24'h000100) begin errors++; $display("FAIL sw_addr2: got %h expected 000100", sdram_addr); end
        burst(1'b1, we, addr, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sw_finish_timeout: got %b expected 1", ok); end
    endtask

    task automatic test_round_robin();
        logic we; logic [23:0] addr; bit ok;
        logic        exp_we[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [23:0] exp_addr[4] = '{24'h800000, 24'h000000, 24'h800100, 24'h000100};
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd500;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            burst(i == 3, we, addr, ok);
            checks++; if (!ok || we !== exp_we[i]) begin errors++; $display("FAIL rr_we[%0d]: got %b expected %b", i, we, exp_we[i]); end
            checks++; if (!ok || addr !== exp_addr[i]) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, addr, exp_addr[i]); end
        end
    endtask

    task automatic test_urgent_read();
        logic we; logic [23:0] addr; bit ok;
        int bad = 0;
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            burst(i == 3, we, addr, ok);
            if (!ok || we !== 1'b0 || addr !== 24'h800000 + 24'(i * 256)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL urgent_reads: got %0d bad bursts expected 0", bad); end
    endtask

    task automatic test_frame_swap();
        logic we; logic [23:0] addr; bit ok;
        int bad = 0;
        int seen = 0;
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd1000;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            burst(1'b0, we, addr, ok);
            if (!ok || we !== 1'b1 || addr !== 24'(i * 256)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL fs_writes: got %0d bad bursts expected 0", bad); end
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (sdram_req !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL fs_blocked: got %0d req cycles expected 0", seen); end
        wr_fifo_level = '0;
        pulse_wfs();
        checks++; if (wr_bank !== 1'b1) begin errors++; $display("FAIL fs_wr_bank: got %b expected 1", wr_bank); end
        checks++; if (frame_drop_cnt !== 8'd0) begin errors++; $display("FAIL fs_no_drop: got %0d expected 0", frame_drop_cnt); end
        @(posedge Clk);
        #1 rd_frame_start = 1'b1;
        @(posedge Clk);
        #1 rd_frame_start = 1'b0;
        @(negedge Clk);
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL fs_rd_bank: got %b expected 0", rd_bank); end
        rd_fifo_level = 10'd500;
        burst(1'b1, we, addr, ok);
        checks++; if (!ok || we !== 1'b0 || addr !== 24'h000000) begin errors++; $display("FAIL fs_read_addr: got we=%b addr=%h expected we=0 addr=000000", we, addr); end
    endtask

    task automatic test_drop();
        logic we; logic [23:0] addr; bit ok;
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd1000;
        do_reset();
        for (int i = 0; i < 10; i++) burst(i == 9, we, addr, ok);
        pulse_wfs();
        checks++; if (frame_drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_one: got %0d expected 1", frame_drop_cnt); end
        checks++; if (wr_bank !== 1'b0) begin errors++; $display("FAIL drop_wr_bank: got %b expected 0", wr_bank); end
        wr_fifo_level = 10'd256;
        burst(1'b1, we, addr, ok);
        checks++; if (!ok || we !== 1'b1 || addr !== 24'h000000) begin errors++; $display("FAIL drop_restart_addr: got we=%b addr=%h expected we=1 addr=000000", we, addr); end
        for (int i = 0; i < 253; i++) pulse_wfs();
        checks++; if (frame_drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d expected 254", frame_drop_cnt); end
        for (int i = 0; i < 46; i++) pulse_wfs();
        checks++; if (frame_drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d expected 255", frame_drop_cnt); end
    endtask

    task automatic test_wfs_in_busy();
        logic we; logic [23:0] addr; bit ok;
        bit got = 1'b0;
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd1000;
        do_reset();
        for (int i = 0; i < 3; i++) burst(1'b0, we, addr, ok);
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (sdram_req === 1'b1) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1 || sdram_addr !== 24'h000300) begin errors++; $display("FAIL wb_req: got req=%b addr=%h expected req=1 addr=000300", got, sdram_addr); end
        sdram_ack = 1'b1;
        @(posedge Clk);
        #1 sdram_ack = 1'b0;
        wr_frame_start = 1'b1;
        @(posedge Clk);
        #1 wr_frame_start = 1'b0;
        @(negedge Clk);
        checks++; if (frame_drop_cnt !== 8'd0) begin errors++; $display("FAIL wb_pending: got %0d expected 0", frame_drop_cnt); end
        @(posedge Clk);
        #1 sdram_done = 1'b1;
        @(posedge Clk);
        #1 sdram_done = 1'b0;
        @(negedge Clk);
        checks++; if (frame_drop_cnt !== 8'd1) begin errors++; $display("FAIL wb_applied: got %0d expected 1", frame_drop_cnt); end
        burst(1'b1, we, addr, ok);
        checks++; if (!ok || we !== 1'b1 || addr !== 24'h000000) begin errors++; $display("FAIL wb_next_addr: got we=%b addr=%h expected we=1 addr=000000", we, addr); end
    endtask

    task automatic test_reset_in_req();
        logic we; logic [23:0] addr; bit ok;
        bit got = 1'b0;
        wr_fifo_level = 10'd256;
        rd_fifo_level = 10'd1000;
        do_reset();
        burst(1'b0, we, addr, ok);
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (sdram_req === 1'b1) begin got = 1'b1; break; end
        end
        checks++; if (got !== 1'b1 || sdram_addr !== 24'h000100) begin errors++; $display("FAIL rr_pre: got req=%b addr=%h expected req=1 addr=000100", got, sdram_addr); end
        Rst = 1'b1;
        wr_fifo_level = '0;
        @(posedge Clk);
        @(negedge Clk);
        checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL rir_req: got %b expected 0", sdram_req); end
        checks++; if (sdram_we !== 1'b0) begin errors++; $display("FAIL rir_we: got %b expected 0", sdram_we); end
        checks++; if (sdram_addr !== 24'h0) begin errors++; $display("FAIL rir_addr: got %h expected 000000", sdram_addr); end
        checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin errors++; $display("FAIL rir_banks: got wr=%b rd=%b expected wr=0 rd=1", wr_bank, rd_bank); end
        #1 Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_urgent_read();
        test_frame_swap();
        test_drop();
        test_wfs_in_busy();
        test_reset_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_frame_arbiter.md
# sdram_frame_arbiter

Frame-buffer scheduler sitting between the camera write FIFO, the TFT read FIFO (which feeds the 800×480 16-bit TFT timing generator) and the single SDRAM burst-controller command port. It decides each cycle whether the next SDRAM burst is a camera write or a display read, and generates burst addresses. It manages ping-pong frame banks so the display always reads the last fully written frame. It also counts camera frames dropped because they were incomplete.

## Interface
Parameters:
- BURST_LEN, 256: words per SDRAM burst (power of two)
- FRAME_WORDS, 384000: words per frame (800×480); must be a multiple of BURST_LEN
- ADDR_W, 24: SDRAM word-address width; MSB selects bank, lower ADDR_W-1 bits are the frame offset
- LVL_W, 10: FIFO level width
- RD_FIFO_DEPTH, 1024: TFT read FIFO depth in words
- RD_LOW, 256: read-FIFO level below which reads are urgent

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  reset; one clock, synchronous, active-high
- wr_fifo_level  in  LVL_W  words waiting in the camera write FIFO
- rd_fifo_level  in  LVL_W  words held in the TFT read FIFO
- wr_frame_start  in  1  one-cycle pulse, camera frame start, already in Clk domain
- rd_frame_start  in  1  one-cycle pulse, TFT VS start, already in Clk domain
- sdram_req  out  1  burst command valid
- sdram_we  out  1  1 = write burst, 0 = read burst; valid with sdram_req
- sdram_addr  out  ADDR_W  burst start word address; valid with sdram_req
- sdram_ack  in  1  command accepted (sampled only while sdram_req=1)
- sdram_done  in  1  one-cycle pulse, current burst complete
- wr_bank  out  1  bank currently written by the camera
- rd_bank  out  1  bank currently read by the display
- frame_drop_cnt  out  8  saturating count of incomplete camera frames

## Operation
- State machine: IDLE → REQ → BUSY → IDLE.
- Eligibility is evaluated in IDLE only:
  - write eligible: wr_fifo_level ≥ BURST_LEN and wr_off < FRAME_WORDS.
  - read eligible: rd_fifo_level ≤ RD_FIFO_DEPTH−BURST_LEN and rd_off < FRAME_WORDS.
- Grant rules:
  - read eligible and rd_fifo_level < RD_LOW → read.
  - otherwise, exactly one eligible → that one.
  - both eligible → the opposite of last_grant (round-robin).
  - none eligible → stay IDLE.
- On grant: register sdram_we and sdram_addr = {bank, offset}, where bank/offset are wr_bank/wr_off for a write and rd_bank/rd_off for a read. Update last_grant. Go to REQ.
- REQ: hold sdram_req=1 with stable sdram_we/sdram_addr until sdram_ack=1, then go to BUSY with sdram_req=0.
- BUSY: on sdram_done, add BURST_LEN to the granted stream's offset, then go to IDLE.
- wr_frame_start sets pending flag wfs. wfs is applied in IDLE, or on the sdram_done edge of a write burst. Applying wfs:
  - if wr_off == FRAME_WORDS: ready_bank ← wr_bank, wr_bank toggles, have_frame ← 1.
  - else: frame_drop_cnt +1, saturating at 255.
  - in both cases wr_off ← 0 and wfs clears.
- rd_frame_start sets pending flag rfs, applied at the same points for reads. Applying rfs: rd_off ← 0, rd_bank ← ready_bank if have_frame, rfs clears.
- Pending flags are applied before the same-cycle IDLE eligibility evaluation.
- A second frame-start pulse while its flag is already pending is absorbed (no additional effect).
- Rst mid-burst: abandons the burst immediately. The SDRAM controller is reset by the same Rst.

## Timing
- Reset values: sdram_req 0, sdram_we 0, sdram_addr 0, wr_bank 0, rd_bank 1, ready_bank 1, frame_drop_cnt 0. Internal: state IDLE, wr_off 0, rd_off 0, last_grant = write, wfs/rfs 0, have_frame 0.
- Grant decision in IDLE at edge t → sdram_req=1 from t+1.
- sdram_ack=1 sampled at edge t+k → sdram_req=0 from t+k+1.
- sdram_ack in the same cycle that sdram_req first rises is legal (one-cycle request).
- sdram_done sampled at edge d → offset updated at d, state IDLE at d+1; earliest next sdram_req at d+2.
- sdram_done or sdram_ack outside BUSY/REQ respectively: ignored.

## Test plan
- Rst then wr_fifo_level=256, rd_fifo_level=1000 → one write request: sdram_we=1, sdram_addr=0x000000, sdram_req high 1 cycle after grant, drop 1 cycle after ack.
- Both eligible, rd_fifo_level=500 → grants alternate read, write, read starting with read (last_grant reset = write). Read addresses 0x800000, 0x800100.
- rd_fifo_level=100 with write also eligible for 4 consecutive decisions → 4 consecutive reads, no write.
- Write 1500 bursts (384000 words), then wr_frame_start → wr_bank=1. Then rd_frame_start → rd_bank=0, next read addr 0x000000. Write eligibility blocks at wr_off=FRAME_WORDS until the frame start.
- wr_frame_start after 10 bursts → frame_drop_cnt=1, wr_bank stays 0, next write addr 0x000000. 300 such pulses → saturates at 255.
- wr_frame_start during BUSY of a write burst → offset reset applied on that sdram_done. Rst asserted while in REQ → sdram_req=0 on the next cycle, all outputs at reset values.
